// File: rtl/uart_sample_packetizer_if.sv
// Sample-capture and byte-transmitter signal bundle for uart_sample_packetizer.
// Latency: none (wires only).
// Backpressure: o_Sample_Ready gates sample writes; i_Tx_Active/i_Tx_Done gate byte strobes.
//
// Signals (direction as seen by the packetizer):
//   i_Sample_Valid / i_Sample / o_Sample_Ready : sample write handshake
//   i_Clear_Ovf / o_Overflow                   : sticky drop flag and its clear
//   o_Tx_DV / o_Tx_Byte                        : one-cycle byte strobe and held byte
//   i_Tx_Active / i_Tx_Done                    : transmitter busy / done levels
//   o_Busy                                     : frame in progress or samples queued
interface uart_sample_packetizer_if #(
    parameter int SAMPLE_WIDTH = 16
);
    logic                    i_Sample_Valid;
    logic [SAMPLE_WIDTH-1:0] i_Sample;
    logic                    o_Sample_Ready;
    logic                    i_Clear_Ovf;
    logic                    o_Overflow;
    logic                    o_Tx_DV;
    logic [7:0]              o_Tx_Byte;
    logic                    i_Tx_Active;
    logic                    i_Tx_Done;
    logic                    o_Busy;

    // Packetizer side.
    modport slave (
        input  i_Sample_Valid, i_Sample, i_Clear_Ovf, i_Tx_Active, i_Tx_Done,
        output o_Sample_Ready, o_Overflow, o_Tx_DV, o_Tx_Byte, o_Busy
    );

    // Sample source / transmitter side.
    modport master (
        output i_Sample_Valid, i_Sample, i_Clear_Ovf, i_Tx_Active, i_Tx_Done,
        input  o_Sample_Ready, o_Overflow, o_Tx_DV, o_Tx_Byte, o_Busy
    );
endinterface

// File: rtl/uart_sample_packetizer.sv
// Buffers sample words and frames each as HEADER_BYTE, sample bytes MSB-first, XOR checksum.
// Latency: header strobe 3 cycles after a write into an empty FIFO with the FSM idle.
// Backpressure: o_Sample_Ready = !full (writes while full are dropped and flagged);
//   a byte is strobed only when the transmitter shows neither Active nor Done.
//
// Ports: i_Clock, i_Rst_n (async active-low) and the slave modport of
// uart_sample_packetizer_if carrying the sample, overflow, transmitter and busy signals.
module uart_sample_packetizer #(
    parameter int         SAMPLE_WIDTH = 16,
    parameter int         FIFO_DEPTH   = 16,
    parameter logic [7:0] HEADER_BYTE  = 8'hA5
) (
    input  logic                     i_Clock,
    input  logic                     i_Rst_n,
    uart_sample_packetizer_if.slave  bus
);
    localparam int NB = SAMPLE_WIDTH / 8;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(NB + 2);
    localparam logic [IW-1:0] LAST_IDX = IW'(NB + 1);
    localparam logic [AW:0]   PTR_ONE  = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT
    } state_t;

    // ---------------- sample FIFO ----------------
    logic [SAMPLE_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        fifo_empty, fifo_full;
    logic        wr_en, pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign wr_en      = bus.i_Sample_Valid && !fifo_full;

    always_ff @(posedge i_Clock) begin
        if (wr_en) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= bus.i_Sample;
        end
    end

    // ---------------- framing FSM state ----------------
    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
    logic [7:0]              csum_q, csum_d;
    logic                    tx_dv_q, tx_dv_d;
    logic [7:0]              tx_byte_q, tx_byte_d;
    logic                    done_prev_q, done_prev_d;
    logic                    ovf_q, ovf_d;
    logic                    done_rise;
    logic                    tx_idle;

    // Done is a level that may last several cycles; only its rising edge ends a byte.
    assign done_rise   = bus.i_Tx_Done && !done_prev_q;
    assign tx_idle     = !bus.i_Tx_Active && !bus.i_Tx_Done;
    assign done_prev_d = bus.i_Tx_Done;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        csum_d    = csum_q;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        pop       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                pop     = 1'b1;
                shift_d = fifo_mem[rd_ptr_q[AW-1:0]];
                csum_d  = 8'h00;
                idx_d   = '0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                // Waiting for both levels low also covers a transmitter still
                // finishing a byte from before a reset.
                if (tx_idle) begin
                    tx_dv_d = 1'b1;
                    state_d = ST_WAIT;
                    if (idx_q == '0) begin
                        tx_byte_d = HEADER_BYTE;
                    end else if (idx_q == LAST_IDX) begin
                        tx_byte_d = csum_q;
                    end else begin
                        // Sample bytes leave from the top of the shift register.
                        tx_byte_d = shift_q[SAMPLE_WIDTH-1 -: 8];
                        csum_d    = csum_q ^ shift_q[SAMPLE_WIDTH-1 -: 8];
                        shift_d   = shift_q << 8;
                    end
                end
            end
            ST_WAIT: begin
                if (done_rise) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d   = idx_q + IW'(1);
                        state_d = ST_SEND;
                    end else if (!fifo_empty) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Set has priority over a same-cycle clear so no drop goes unreported.
    always_comb begin
        ovf_d = ovf_q;
        if (bus.i_Sample_Valid && fifo_full) begin
            ovf_d = 1'b1;
        end else if (bus.i_Clear_Ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            shift_q     <= '0;
            csum_q      <= 8'h00;
            tx_dv_q     <= 1'b0;
            tx_byte_q   <= 8'h00;
            done_prev_q <= 1'b0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            csum_q      <= csum_d;
            tx_dv_q     <= tx_dv_d;
            tx_byte_q   <= tx_byte_d;
            done_prev_q <= done_prev_d;
            ovf_q       <= ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    assign bus.o_Sample_Ready = !fifo_full;
    assign bus.o_Overflow     = ovf_q;
    assign bus.o_Tx_DV        = tx_dv_q;
    assign bus.o_Tx_Byte      = tx_byte_q;
    assign bus.o_Busy         = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_sample_packetizer.sv
// Bench for uart_sample_packetizer: transmitter model, expected-byte queue, negedge monitor.
// Latency: header strobe timing checked against the 3-cycle figure.
// Backpressure: FIFO fill, drop/overflow flag, stretched Done and reset mid-frame exercised.
module tb_uart_sample_packetizer;
    localparam int SW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_sample_packetizer_if #(.SAMPLE_WIDTH(SW)) bus ();

    uart_sample_packetizer #(
        .SAMPLE_WIDTH (SW),
        .FIFO_DEPTH   (4),
        .HEADER_BYTE  (8'hA5)
    ) dut (
        .i_Clock (clk),
        .i_Rst_n (rst_n),
        .bus     (bus)
    );

    int         n_chk  = 0;
    int         n_pass = 0;
    logic [8:0] exp_q[$];          // {is_header, byte}
    int         cyc = 0;
    int         last_done_cyc = 0;
    bit         tx_busy = 0;
    bit         stall = 0;
    bit         gap_chk = 0;
    bit         prev_dv = 0;
    logic       ad_pos = 1'b0;
    int         act_lo = 1, act_hi = 1, done_lo = 1, done_hi = 1;
    int         a_n, d_n;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic void push_lit(input logic [7:0] b0, input logic [7:0] b1,
                                     input logic [7:0] b2, input logic [7:0] b3);
        exp_q.push_back({1'b1, b0});
        exp_q.push_back({1'b0, b1});
        exp_q.push_back({1'b0, b2});
        exp_q.push_back({1'b0, b3});
    endfunction

    function automatic void push_frame(input logic [15:0] s);
        push_lit(8'hA5, s[15:8], s[7:0], s[15:8] ^ s[7:0]);
    endfunction

    // Called at a negedge; the write is taken at the following posedge.
    task automatic wr(input logic [15:0] s);
        bus.i_Sample       = s;
        bus.i_Sample_Valid = 1'b1;
        @(negedge clk);
        bus.i_Sample_Valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || tx_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            n_chk++;
            $display("FAIL drain_timeout: pending=%0d tx_busy=%0d", exp_q.size(), tx_busy);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_q_le(input int target, input int budget);
        int n = 0;
        while (exp_q.size() > target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            n_chk++;
            $display("FAIL queue_wait_timeout: pending=%0d target=%0d", exp_q.size(), target);
        end
    endtask

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        ad_pos <= bus.i_Tx_Active | bus.i_Tx_Done;
    end

    // Transmitter model: Active for a_n cycles (longer while stalled), then Done for d_n cycles.
    initial begin
        bus.i_Tx_Active = 1'b0;
        bus.i_Tx_Done   = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.o_Tx_DV && rst_n) begin
                a_n = $urandom_range(act_hi, act_lo);
                d_n = $urandom_range(done_hi, done_lo);
                tx_busy = 1;
                bus.i_Tx_Active = 1'b1;
                repeat (a_n) @(negedge clk);
                while (stall) @(negedge clk);
                bus.i_Tx_Active = 1'b0;
                bus.i_Tx_Done   = 1'b1;
                last_done_cyc   = cyc;
                repeat (d_n) @(negedge clk);
                bus.i_Tx_Done = 1'b0;
                tx_busy = 0;
            end
        end
    end

    // Monitor: every strobe is checked against the expected queue.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_n && bus.o_Tx_DV) begin
            chk("dv_back_to_back", prev_dv, 0);
            chk("dv_while_tx_busy", ad_pos, 0);
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_dv: got byte %0h expected no strobe (t=%0t)",
                         bus.o_Tx_Byte, $time);
            end else begin
                e = exp_q.pop_front();
                chk("tx_byte", bus.o_Tx_Byte, e[7:0]);
                if (e[8] && gap_chk) begin
                    chk("frame_gap_cycles", cyc - last_done_cyc, 3);
                    gap_chk = 0;
                end
            end
        end
        prev_dv = bus.o_Tx_DV;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [15:0] s;
        bus.i_Sample_Valid = 1'b0;
        bus.i_Sample       = '0;
        bus.i_Clear_Ovf    = 1'b0;

        // Reset values
        #12;
        chk("rst_dv", bus.o_Tx_DV, 0);
        chk("rst_byte", bus.o_Tx_Byte, 0);
        chk("rst_ovf", bus.o_Overflow, 0);
        chk("rst_busy", bus.o_Busy, 0);
        chk("rst_ready", bus.o_Sample_Ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single sample, header latency, busy release
        push_lit(8'hA5, 8'h12, 8'h34, 8'h26);
        wr(16'h1234);
        chk("busy_after_write", bus.o_Busy, 1);
        n = 0;
        while (!bus.o_Tx_DV && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("header_latency", n, 3);
        drain(200);
        chk("busy_after_frame", bus.o_Busy, 0);

        // 2: back-to-back frames, no idle cycle between them
        push_lit(8'hA5, 8'h00, 8'hFF, 8'hFF);
        push_lit(8'hA5, 8'hFF, 8'hFF, 8'h00);
        wr(16'h00FF);
        wr(16'hFFFF);
        wait_q_le(4, 300);
        gap_chk = 1;
        drain(300);
        chk("gap_check_done", gap_chk, 0);

        // 3: fill while the transmitter stalls, drop, overflow set/clear
        stall = 1;
        push_lit(8'hA5, 8'hAB, 8'hCD, 8'h66);
        wr(16'hABCD);
        n = 0;
        while (!tx_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stall_engaged", tx_busy, 1);
        chk("ready_before_fill", bus.o_Sample_Ready, 1);
        push_lit(8'hA5, 8'h00, 8'h01, 8'h01); wr(16'h0001);
        push_lit(8'hA5, 8'h00, 8'h02, 8'h02); wr(16'h0002);
        push_lit(8'hA5, 8'h00, 8'h03, 8'h03); wr(16'h0003);
        push_lit(8'hA5, 8'h00, 8'h04, 8'h04); wr(16'h0004);
        chk("ready_when_full", bus.o_Sample_Ready, 0);
        chk("ovf_before_drop", bus.o_Overflow, 0);
        wr(16'h0005);
        chk("ovf_after_drop", bus.o_Overflow, 1);
        bus.i_Clear_Ovf = 1'b1;
        @(negedge clk);
        bus.i_Clear_Ovf = 1'b0;
        chk("ovf_cleared", bus.o_Overflow, 0);
        bus.i_Clear_Ovf = 1'b1;
        wr(16'h0006);
        bus.i_Clear_Ovf = 1'b0;
        chk("ovf_set_wins", bus.o_Overflow, 1);
        stall = 0;
        drain(600);
        chk("ready_after_drain", bus.o_Sample_Ready, 1);

        // 4: Done held three cycles per byte
        act_lo = 2; act_hi = 2; done_lo = 3; done_hi = 3;
        push_lit(8'hA5, 8'h5A, 8'hC3, 8'h99);
        push_lit(8'hA5, 8'h80, 8'h01, 8'h81);
        wr(16'h5AC3);
        wr(16'h8001);
        drain(400);

        // 5: reset during the second sample byte with two samples queued
        act_lo = 3; act_hi = 3; done_lo = 1; done_hi = 1;
        push_frame(16'h1111);
        push_frame(16'h2222);
        push_frame(16'h3333);
        wr(16'h1111);
        wr(16'h2222);
        wr(16'h3333);
        wait_q_le(9, 300);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_dv", bus.o_Tx_DV, 0);
        chk("midrst_byte", bus.o_Tx_Byte, 0);
        chk("midrst_ovf", bus.o_Overflow, 0);
        chk("midrst_busy", bus.o_Busy, 0);
        chk("midrst_ready", bus.o_Sample_Ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        drain(100);
        chk("busy_after_rst", bus.o_Busy, 0);
        push_lit(8'hA5, 8'h42, 8'h42, 8'h00);
        wr(16'h4242);
        drain(200);

        // 6: random samples and transmitter timing
        act_lo = 1; act_hi = 3; done_lo = 1; done_hi = 3;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            n = 0;
            while (!bus.o_Sample_Ready && n < 500) begin
                @(negedge clk);
                n++;
            end
            if (n >= 500) begin
                n_chk++;
                $display("FAIL ready_timeout: frame %0d", i);
                break;
            end
            s = 16'($urandom);
            push_frame(s);
            wr(s);
        end
        drain(5000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
